// File: rtl/cpu_types_pkg.sv
// ----------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the multi-cycle CPU control path: MIPS opcode and funct
// encodings, ALU operation codes, control-FSM states and the mux-select
// encodings driven by mc_control_unit.
// ----------------------------------------------------------------------------
package cpu_types_pkg;

   typedef enum logic [5:0] {
      OP_RTYPE = 6'h00,
      OP_J     = 6'h02,
      OP_JAL   = 6'h03,
      OP_BEQ   = 6'h04,
      OP_BNE   = 6'h05,
      OP_ADDI  = 6'h08,
      OP_ADDIU = 6'h09,
      OP_SLTI  = 6'h0A,
      OP_SLTIU = 6'h0B,
      OP_ANDI  = 6'h0C,
      OP_ORI   = 6'h0D,
      OP_XORI  = 6'h0E,
      OP_LUI   = 6'h0F,
      OP_LW    = 6'h23,
      OP_SW    = 6'h2B,
      OP_HALT  = 6'h3F
   } opcode_t;

   typedef enum logic [5:0] {
      FN_SLL  = 6'h00,
      FN_SRL  = 6'h02,
      FN_JR   = 6'h08,
      FN_ADD  = 6'h20,
      FN_ADDU = 6'h21,
      FN_SUB  = 6'h22,
      FN_SUBU = 6'h23,
      FN_AND  = 6'h24,
      FN_OR   = 6'h25,
      FN_XOR  = 6'h26,
      FN_NOR  = 6'h27,
      FN_SLT  = 6'h2A,
      FN_SLTU = 6'h2B
   } funct_t;

   typedef enum logic [3:0] {
      ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
      ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
   } aluop_t;

   typedef enum logic [2:0] {
      FETCH, DECODE, EXEC, MEM, WB, HALT
   } mc_state_t;

   // PC source select
   localparam logic [1:0] PCSRC_RS     = 2'd0;
   localparam logic [1:0] PCSRC_JUMP   = 2'd1;
   localparam logic [1:0] PCSRC_BRANCH = 2'd2;
   localparam logic [1:0] PCSRC_NEXT   = 2'd3;

   // Register-file destination select
   localparam logic [1:0] REGDST_RT  = 2'd0;
   localparam logic [1:0] REGDST_RD  = 2'd1;
   localparam logic [1:0] REGDST_R31 = 2'd2;

   // Write-back source select
   localparam logic [1:0] M2R_ALU = 2'd0;
   localparam logic [1:0] M2R_MEM = 2'd1;
   localparam logic [1:0] M2R_PC4 = 2'd2;

   // ALU B-operand select
   localparam logic [1:0] ALUSRC_RT  = 2'd0;
   localparam logic [1:0] ALUSRC_IMM = 2'd1;
   localparam logic [1:0] ALUSRC_LUI = 2'd2;

endpackage

// File: rtl/mc_decode.sv
// ----------------------------------------------------------------------------
// mc_decode
// Purely combinational datapath-select decode of the instruction register.
// Ports:
//   opcode_i  - IR[31:26]
//   funct_i   - IR[5:0]
//   alu_ctr_o - ALU operation
//   alu_src_o - ALU B operand select (rt / extended imm16 / imm16 << 16)
//   reg_dst_o - destination register select (rt / rd / r31)
//   ext_op_o  - 1 = sign-extend imm16, 0 = zero-extend
// ----------------------------------------------------------------------------
module mc_decode
   import cpu_types_pkg::*;
(
   input  logic [5:0] opcode_i,
   input  logic [5:0] funct_i,
   output aluop_t     alu_ctr_o,
   output logic [1:0] alu_src_o,
   output logic [1:0] reg_dst_o,
   output logic       ext_op_o
);

   // NOTE: every output gets a default before the case so no path leaves a
   // value unassigned, which would otherwise infer a latch.
   always_comb begin
      alu_ctr_o = ALU_ADD;
      alu_src_o = ALUSRC_RT;
      reg_dst_o = REGDST_RT;
      ext_op_o  = 1'b1;
      case (opcode_i)
         OP_RTYPE: begin
            reg_dst_o = REGDST_RD;
            case (funct_i)
               FN_SLL:          alu_ctr_o = ALU_SLL;
               FN_SRL:          alu_ctr_o = ALU_SRL;
               FN_SUB, FN_SUBU: alu_ctr_o = ALU_SUB;
               FN_AND:          alu_ctr_o = ALU_AND;
               FN_OR:           alu_ctr_o = ALU_OR;
               FN_XOR:          alu_ctr_o = ALU_XOR;
               FN_NOR:          alu_ctr_o = ALU_NOR;
               FN_SLT:          alu_ctr_o = ALU_SLT;
               FN_SLTU:         alu_ctr_o = ALU_SLTU;
               default:         alu_ctr_o = ALU_ADD;
            endcase
         end
         OP_JAL:         reg_dst_o = REGDST_R31;
         OP_BEQ, OP_BNE: alu_ctr_o = ALU_SUB;
         OP_ADDI, OP_ADDIU, OP_LW, OP_SW: alu_src_o = ALUSRC_IMM;
         OP_SLTI: begin
            alu_ctr_o = ALU_SLT;
            alu_src_o = ALUSRC_IMM;
         end
         OP_SLTIU: begin
            alu_ctr_o = ALU_SLTU;
            alu_src_o = ALUSRC_IMM;
         end
         // Logical immediates zero-extend their operand
         OP_ANDI: begin
            alu_ctr_o = ALU_AND;
            alu_src_o = ALUSRC_IMM;
            ext_op_o  = 1'b0;
         end
         OP_ORI: begin
            alu_ctr_o = ALU_OR;
            alu_src_o = ALUSRC_IMM;
            ext_op_o  = 1'b0;
         end
         OP_XORI: begin
            alu_ctr_o = ALU_XOR;
            alu_src_o = ALUSRC_IMM;
            ext_op_o  = 1'b0;
         end
         OP_LUI:  alu_src_o = ALUSRC_LUI;
         default: ;
      endcase
   end

endmodule

// File: rtl/mc_control_unit.sv
// ----------------------------------------------------------------------------
// mc_control_unit
// Multi-cycle CPU control FSM: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Holds the instruction register and a memory wait counter; a wait that
// reaches WAIT_MAX without a hit sets the sticky timeout flag and halts.
// Ports:
//   CLK, nRST        - clock, asynchronous active-low reset
//   instr_in, ihit   - instruction memory word / access done
//   dhit             - data memory access done
//   zero             - ALU zero flag (branch resolution)
//   iREN/dREN/dWEN   - memory enables
//   IRWr, PCWr, PCSrc, RegWr, RegDst, MemToReg, ALUSrc, ALUctr, ExtOp
//                    - datapath controls
//   halt, timeout    - sticky status flags
//   state            - current FSM state (debug)
// ----------------------------------------------------------------------------
module mc_control_unit
   import cpu_types_pkg::*;
#(
   parameter int WORD_W   = 32,
   parameter int WAIT_MAX = 15,
   parameter int CNT_W    = 4
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic [WORD_W-1:0] instr_in,
   input  logic              ihit,
   input  logic              dhit,
   input  logic              zero,
   output logic              iREN,
   output logic              dREN,
   output logic              dWEN,
   output logic              IRWr,
   output logic              PCWr,
   output logic [1:0]        PCSrc,
   output logic              RegWr,
   output logic [1:0]        RegDst,
   output logic [1:0]        MemToReg,
   output logic [1:0]        ALUSrc,
   output aluop_t            ALUctr,
   output logic              ExtOp,
   output logic              halt,
   output logic              timeout,
   output mc_state_t         state
);

   localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);

   mc_state_t         state_q;
   logic [WORD_W-1:0] ir_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              halt_q;
   logic              timeout_q;

   logic [5:0] opcode;
   logic [5:0] funct;
   logic is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_jr, is_nop;
   logic is_ctl, take_branch, at_limit;

   assign opcode      = ir_q[31:26];
   assign funct       = ir_q[5:0];
   assign is_lw       = (opcode == OP_LW);
   assign is_sw       = (opcode == OP_SW);
   assign is_beq      = (opcode == OP_BEQ);
   assign is_bne      = (opcode == OP_BNE);
   assign is_j        = (opcode == OP_J);
   assign is_jal      = (opcode == OP_JAL);
   assign is_jr       = (opcode == OP_RTYPE) && (funct == FN_JR);
   assign is_nop      = (ir_q == '0);
   assign is_ctl      = is_beq | is_bne | is_j | is_jal | is_jr;
   assign take_branch = (is_beq & zero) | (is_bne & ~zero);
   assign at_limit    = (cnt_q == WAIT_LIM);

   mc_decode u_decode (
      .opcode_i  (opcode),
      .funct_i   (funct),
      .alu_ctr_o (ALUctr),
      .alu_src_o (ALUSrc),
      .reg_dst_o (RegDst),
      .ext_op_o  (ExtOp)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   // NOTE: the IR is a single register, not an array, so it is reset along
   // with the rest of the state; a cleared IR decodes as a nop.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q   <= FETCH;
         ir_q      <= '0;
         cnt_q     <= '0;
         halt_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         case (state_q)
            FETCH: begin
               if (ihit) begin
                  ir_q    <= instr_in;
                  state_q <= DECODE;
               end else if (at_limit) begin
                  state_q   <= HALT;
                  halt_q    <= 1'b1;
                  timeout_q <= 1'b1;
               end else begin
                  // Leaving at the limit means the counter saturates there
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DECODE: begin
               if (opcode == OP_HALT) begin
                  state_q <= HALT;
                  halt_q  <= 1'b1;
               end else begin
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               if (is_ctl) begin
                  state_q <= FETCH;
                  cnt_q   <= '0;
               end else if (is_lw || is_sw) begin
                  state_q <= MEM;
                  cnt_q   <= '0;
               end else begin
                  state_q <= WB;
               end
            end
            MEM: begin
               if (dhit) begin
                  state_q <= is_lw ? WB : FETCH;
                  cnt_q   <= '0;
               end else if (at_limit) begin
                  state_q   <= HALT;
                  halt_q    <= 1'b1;
                  timeout_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            WB: begin
               state_q <= FETCH;
               cnt_q   <= '0;
            end
            default: state_q <= HALT;
         endcase
      end
   end

   // Enables and strobes respond to hits in the same cycle, so they are
   // decoded from the state rather than registered. Gating with nRST keeps
   // them low for the whole reset interval, not just after the next edge.
   always_comb begin
      iREN     = 1'b0;
      dREN     = 1'b0;
      dWEN     = 1'b0;
      IRWr     = 1'b0;
      PCWr     = 1'b0;
      PCSrc    = PCSRC_NEXT;
      RegWr    = 1'b0;
      MemToReg = M2R_ALU;
      if (nRST) begin
         case (state_q)
            FETCH: begin
               iREN = 1'b1;
               IRWr = ihit;
               PCWr = ihit;
            end
            EXEC: begin
               if (take_branch) begin
                  PCWr  = 1'b1;
                  PCSrc = PCSRC_BRANCH;
               end else if (is_j || is_jal) begin
                  PCWr  = 1'b1;
                  PCSrc = PCSRC_JUMP;
               end else if (is_jr) begin
                  PCWr  = 1'b1;
                  PCSrc = PCSRC_RS;
               end
               if (is_jal) begin
                  RegWr    = 1'b1;
                  MemToReg = M2R_PC4;
               end
            end
            MEM: begin
               dREN = is_lw;
               dWEN = is_sw;
            end
            WB: begin
               RegWr    = ~is_nop;
               MemToReg = is_lw ? M2R_MEM : M2R_ALU;
            end
            default: ;
         endcase
      end
   end

   assign halt    = halt_q;
   assign timeout = timeout_q;
   assign state   = state_q;

endmodule
